// File: rtl/error_check.sv
// -----------------------------------------------------------------------------
// error_check
//
// Frame-integrity checker for the UART receive path, placed after the
// deserializer. On every clock edge where recieved_flag is high it evaluates
// the captured start bit, stop bit and parity bit. It then registers a 3-bit
// error vector and pulses check_done for one cycle. When recieved_flag is low
// the error vector holds its value and check_done stays low.
//
// Optional feature (compile-time macro ERROR_CHECK_STATS_EN):
//   Adds saturating 8-bit frame / parity-error / framing-error counters and a
//   synchronous stats_clear input.
//
// Ports:
//   clock             in   system clock, rising edge
//   reset             in   synchronous, active-high
//   recieved_flag     in   frame-complete qualifier / sampling enable
//   start_bit         in   captured start bit (legal value 0)
//   stop_bit          in   captured stop bit  (legal value 1)
//   parity_bit        in   captured parity bit
//   parity_type [1:0] in   00/11 none, 01 odd, 10 even
//   raw_data    [W-1:0] in captured payload
//   stats_clear       in   (stats build) zero all counters
//   frame_count       out  (stats build) qualified samples, saturating
//   parity_err_count  out  (stats build) parity errors, saturating
//   framing_err_count out  (stats build) start/stop errors, saturating
//   error_flag  [2:0] out  [0] parity, [1] start, [2] stop error
//   check_done        out  one-cycle strobe: error_flag just updated
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module error_check #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  recieved_flag,
    input  logic                  start_bit,
    input  logic                  stop_bit,
    input  logic                  parity_bit,
    input  logic [1:0]            parity_type,
    input  logic [DATA_WIDTH-1:0] raw_data,
`ifdef ERROR_CHECK_STATS_EN
    input  logic                  stats_clear,
    output logic [7:0]            frame_count,
    output logic [7:0]            parity_err_count,
    output logic [7:0]            framing_err_count,
`endif
    output logic [2:0]            error_flag,
    output logic                  check_done
);

    typedef enum logic [1:0] {
        PAR_NONE  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_EVEN  = 2'b10,
        PAR_NONE2 = 2'b11
    } parity_mode_e;

    parity_mode_e w_mode;
    logic         w_par;
    logic         w_parity_err;
    logic         w_start_err;
    logic         w_stop_err;
    logic [2:0]   w_eval;

    logic [2:0]   r_error_flag;
    logic         r_check_done;

    assign w_mode      = parity_mode_e'(parity_type);
    // Reduction over payload and parity bit: 1 means an odd number of ones.
    assign w_par       = ^{raw_data, parity_bit};
    assign w_start_err = start_bit;
    assign w_stop_err  = ~stop_bit;

    // NOTE: every output of a combinational block gets a default first so a
    // missing case arm cannot infer a latch.
    always_comb begin
        w_parity_err = 1'b0;
        case (w_mode)
            PAR_ODD:  w_parity_err = ~w_par;
            PAR_EVEN: w_parity_err = w_par;
            default:  w_parity_err = 1'b0;
        endcase
    end

    assign w_eval = {w_stop_err, w_start_err, w_parity_err};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_error_flag <= 3'b000;
            r_check_done <= 1'b0;
        end else begin
            r_check_done <= recieved_flag;
            if (recieved_flag) begin
                r_error_flag <= w_eval;
            end
        end
    end

    assign error_flag = r_error_flag;
    assign check_done = r_check_done;

`ifdef ERROR_CHECK_STATS_EN
    logic [7:0] r_frame_count;
    logic [7:0] r_parity_err_count;
    logic [7:0] r_framing_err_count;

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic en);
        return (en && (value != 8'hFF)) ? value + 8'd1 : value;
    endfunction

    // Counters see the freshly evaluated vector, so they stay in step with
    // error_flag. A frame with both start and stop errors counts once.
    always_ff @(posedge clock) begin
        if (reset || stats_clear) begin
            r_frame_count       <= 8'd0;
            r_parity_err_count  <= 8'd0;
            r_framing_err_count <= 8'd0;
        end else if (recieved_flag) begin
            r_frame_count       <= sat_inc(r_frame_count, 1'b1);
            r_parity_err_count  <= sat_inc(r_parity_err_count, w_parity_err);
            r_framing_err_count <= sat_inc(r_framing_err_count, w_start_err | w_stop_err);
        end
    end

    assign frame_count       = r_frame_count;
    assign parity_err_count  = r_parity_err_count;
    assign framing_err_count = r_framing_err_count;
`endif

endmodule

// File: tb/tb_error_check.sv
// -----------------------------------------------------------------------------
// tb_error_check
//
// Directed bench for error_check. The stimulus process drives one frame per
// clock on the falling edge and pushes the hand-computed error vector for
// every qualified sample. A separate monitor pops and compares whenever
// check_done is seen. Define ERROR_CHECK_STATS_EN to exercise the counters too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_error_check;

    logic       clock;
    logic       reset;
    logic       recieved_flag;
    logic       start_bit;
    logic       stop_bit;
    logic       parity_bit;
    logic [1:0] parity_type;
    logic [7:0] raw_data;
    logic [2:0] error_flag;
    logic       check_done;
`ifdef ERROR_CHECK_STATS_EN
    logic       stats_clear;
    logic [7:0] frame_count;
    logic [7:0] parity_err_count;
    logic [7:0] framing_err_count;
`endif

    int         n_checks;
    int         n_errors;
    logic [2:0] exp_q[$];

    error_check #(.DATA_WIDTH(8)) dut (
        .clock             (clock),
        .reset             (reset),
        .recieved_flag     (recieved_flag),
        .start_bit         (start_bit),
        .stop_bit          (stop_bit),
        .parity_bit        (parity_bit),
        .parity_type       (parity_type),
        .raw_data          (raw_data),
`ifdef ERROR_CHECK_STATS_EN
        .stats_clear       (stats_clear),
        .frame_count       (frame_count),
        .parity_err_count  (parity_err_count),
        .framing_err_count (framing_err_count),
`endif
        .error_flag        (error_flag),
        .check_done        (check_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (check_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got check_done=1, expected no strobe (t=%0t)", $time);
            end else begin
                check("error_flag", {5'd0, error_flag}, {5'd0, exp_q.pop_front()});
            end
        end
    end

    // Drive one cycle of inputs (called at a falling edge), push the expected
    // vector for a qualified sample, then advance to the next falling edge.
    task automatic send(input logic flag, input logic st, input logic sp, input logic pb,
                        input logic [1:0] pt, input logic [7:0] rd, input logic [2:0] exp);
        recieved_flag = flag;
        start_bit     = st;
        stop_bit      = sp;
        parity_bit    = pb;
        parity_type   = pt;
        raw_data      = rd;
        if (flag && !reset) exp_q.push_back(exp);
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
`ifdef ERROR_CHECK_STATS_EN
        stats_clear = 1'b0;
`endif
        // Reset held two cycles while a bad frame is presented.
        reset = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
        check("reset_flag_0", {5'd0, error_flag}, 8'h00);
        check("reset_done_0", {7'd0, check_done}, 8'h00);
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
        check("reset_flag_1", {5'd0, error_flag}, 8'h00);
        check("reset_done_1", {7'd0, check_done}, 8'h00);
        reset = 1'b0;
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 3'b110);

        // Single pulse, odd parity satisfied, then check the strobe drops.
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 8'h01, 3'b000);
        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'h01, 3'b000);
        check("done_one_cycle", {7'd0, check_done}, 8'h00);

        // Same frame under even parity and both no-parity encodings.
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 8'h01, 3'b001);
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h01, 3'b000);
        send(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 8'h01, 3'b000);
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 8'h01, 3'b000);
        send(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 8'h01, 3'b000);
        // Odd parity violated, and a multi-bit payload under even parity.
        send(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 8'h01, 3'b001);
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 8'hA5, 3'b000);

        // Garbage frame, then unqualified input changes must not disturb it.
        send(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 8'hFF, 3'b111);
        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        check("hold_flag_0", {5'd0, error_flag}, 8'h07);
        check("hold_done_0", {7'd0, check_done}, 8'h00);
        send(1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 8'h3C, 3'b000);
        check("hold_flag_1", {5'd0, error_flag}, 8'h07);

        // Back-to-back qualified samples with stop bit 1,0,1.
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h55, 3'b000);
        send(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 8'h55, 3'b100);
        send(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 8'h55, 3'b000);
        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h55, 3'b000);
        check("burst_end_done", {7'd0, check_done}, 8'h00);

        // Mid-operation reset clears a non-zero flag.
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 3'b110);
        reset = 1'b1;
        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        check("midreset_flag", {5'd0, error_flag}, 8'h00);
        check("midreset_done", {7'd0, check_done}, 8'h00);
        reset = 1'b0;

`ifdef ERROR_CHECK_STATS_EN
        check("stats_reset_frames", frame_count, 8'd0);
        // Saturation: 300 frames, each with parity and start errors.
        for (int i = 0; i < 300; i++) begin
            send(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 8'h00, 3'b011);
            if (i == 9) begin
                check("stats_frames_10", frame_count, 8'd10);
                check("stats_parity_10", parity_err_count, 8'd10);
            end
        end
        check("stats_frames_sat", frame_count, 8'd255);
        check("stats_parity_sat", parity_err_count, 8'd255);
        check("stats_framing_sat", framing_err_count, 8'd255);
        // Clear wins over a simultaneous qualified error frame.
        stats_clear = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 8'h00, 3'b111);
        stats_clear = 1'b0;
        check("stats_clear_frames", frame_count, 8'd0);
        check("stats_clear_parity", parity_err_count, 8'd0);
        check("stats_clear_framing", framing_err_count, 8'd0);
        // Start and stop error together count as one framing error.
        send(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 3'b110);
        check("stats_one_frame", frame_count, 8'd1);
        check("stats_one_parity", parity_err_count, 8'd0);
        check("stats_one_framing", framing_err_count, 8'd1);
`endif

        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        send(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
        check("pending_expectations", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
